// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 constants, field widths and dot-product sequencer state codes.
package dlfloat_pkg;
  localparam int EXP_W        = 6;
  localparam int MANT_W       = 9;
  localparam int DLF_W        = 1 + EXP_W + MANT_W;
  localparam int DLF_EXP_BIAS = 31;

  localparam logic [DLF_W-1:0] DLF_ZERO = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_INF  = 16'hFFFF;

  // operand issue -> product reg -> accumulator reg
  localparam int PIPE_DEPTH_DEF = 3;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_DRAIN  = 3'd2;
  localparam logic [2:0] ST_OUT_LO = 3'd3;
  localparam logic [2:0] ST_OUT_HI = 3'd4;

  // Operand pair as presented to the multiplier.
  typedef struct packed {
    logic [DLF_W-1:0] a;
    logic [DLF_W-1:0] b;
  } dlf_pair_t;
endpackage

// File: rtl/dlfloat_res_ser.sv
// Two-byte result serializer, low byte first, registered valid/byte/last.
// The low byte is taken from data on load; the high byte is taken from data
// when the low byte is consumed, so the caller holds the word stable meanwhile.
module dlfloat_res_ser (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic        out_last,
  output logic        done
);
  logic       vld_q, vld_d;
  logic       last_q, last_d;
  logic [7:0] byte_q, byte_d;
  logic       done_q, done_d;

  // Next-state: load low byte, advance to high byte, then retire with a done pulse.
  always_comb begin
    vld_d  = vld_q;
    last_d = last_q;
    byte_d = byte_q;
    done_d = 1'b0;
    if (load) begin
      vld_d  = 1'b1;
      last_d = 1'b0;
      byte_d = data[7:0];
    end else if (vld_q && out_ready) begin
      if (!last_q) begin
        last_d = 1'b1;
        byte_d = data[15:8];
      end else begin
        vld_d  = 1'b0;
        last_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Output registers; byte and valid hold while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      byte_q <= 8'h00;
      done_q <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      last_q <= last_d;
      byte_q <= byte_d;
      done_q <= done_d;
    end
  end

  assign out_valid = vld_q;
  assign out_byte  = byte_q;
  assign out_last  = last_q;
  assign done      = done_q;
endmodule

// File: rtl/dlfloat_dot_seq.sv
// DLFloat16 dot-product sequencer: clears the shared MAC accumulator, streams
// operand pairs (zeros as bubbles), drains the pipeline, returns the result
// as two bytes. No arithmetic is done here; operand codes pass through as-is.
module dlfloat_dot_seq
  import dlfloat_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [15:0]      in_b,
  output logic             mac_clr,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [15:0]      mac_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output logic             out_last,
  output logic             done
);
  localparam int DW = $clog2(PIPE_DEPTH + 1);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]    drn_q, drn_d;
  logic [15:0]      res_q, res_d;
  dlf_pair_t        op_q, op_d;
  logic             ser_load;
  logic [15:0]      ser_data;
  logic             ser_done;

  assign busy     = (state_q != ST_IDLE);
  assign in_ready = (state_q == ST_LOAD);
  assign mac_clr  = (state_q == ST_IDLE) && start;
  assign mac_a    = op_q.a;
  assign mac_b    = op_q.b;
  assign done     = ser_done;
  // The capture edge feeds the accumulator straight in; afterwards the held result.
  assign ser_data = ser_load ? mac_acc : res_q;

  // Sequencer next-state; operand register defaults to a zero bubble.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    drn_d    = drn_q;
    res_d    = res_q;
    op_d     = '{a: DLF_ZERO, b: DLF_ZERO};
    ser_load = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len;
          cnt_d   = '0;
          drn_d   = '0;
          state_d = (len == '0) ? ST_DRAIN : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (in_valid) begin
          op_d  = '{a: in_a, b: in_b};
          cnt_d = cnt_q + LEN_W'(1);
          // Exit compare against len keeps the count from ever wrapping.
          if (cnt_q + LEN_W'(1) == len_q) begin
            state_d = ST_DRAIN;
            drn_d   = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (drn_q == DW'(PIPE_DEPTH - 1)) begin
          res_d    = mac_acc;
          ser_load = 1'b1;
          drn_d    = '0;
          state_d  = ST_OUT_LO;
        end else begin
          drn_d = drn_q + DW'(1);
        end
      end
      ST_OUT_LO: if (out_valid && out_ready) state_d = ST_OUT_HI;
      ST_OUT_HI: if (out_valid && out_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Sequencer state, counters, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      res_q   <= 16'h0000;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      res_q   <= res_d;
      op_q    <= op_d;
    end
  end

  dlfloat_res_ser u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .data      (ser_data),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .done      (ser_done)
  );
endmodule

// File: tb/tb_dlfloat_dot_seq.sv
// Scoreboard bench for dlfloat_dot_seq with a behavioural MAC datapath model.
module tb_dlfloat_dot_seq;
  localparam int LEN_W = 8;
  localparam int PD    = 3;

  logic clk = 0, rst = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [LEN_W-1:0] len = '0;
  logic [15:0] in_a = '0, in_b = '0;
  logic busy, in_ready, mac_clr, out_valid, out_last, done;
  logic [15:0] mac_a, mac_b, mac_acc;
  logic [7:0]  out_byte;

  int ncmp = 0, nerr = 0;
  typedef struct { logic [7:0] b; logic last; } exp_t;
  exp_t sb[$];
  logic [15:0] va[16], vb[16];
  logic [15:0] prod_q, acc_q, exp_a, exp_b;

  always #5 clk = ~clk;
  assign mac_acc = acc_q;

  dlfloat_dot_seq #(.LEN_W(LEN_W), .PIPE_DEPTH(PD)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_clr(mac_clr), .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .out_last(out_last), .done(done)
  );

  function automatic real dec(logic [15:0] x);
    real v; int e;
    if (x[14:0] == 15'd0) return 0.0;
    v = 1.0 + real'(x[8:0]) / 512.0;
    e = int'(x[14:9]) - 31;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return x[15] ? -v : v;
  endfunction

  function automatic logic [15:0] enc(real r);
    real m; int e; logic s; int mt;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 0;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    mt = $rtoi((m - 1.0) * 512.0);
    return {s, 6'(e + 31), 9'(mt)};
  endfunction

  function automatic logic [15:0] dp_mul(logic [15:0] a, logic [15:0] b);
    if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
    return enc(dec(a) * dec(b));
  endfunction

  function automatic logic [15:0] dp_add(logic [15:0] a, logic [15:0] b);
    if (a == 16'hFFFF || b == 16'hFFFF) return 16'hFFFF;
    return enc(dec(a) + dec(b));
  endfunction

  // Operands whose products and sums stay exact in a 9-bit mantissa.
  function automatic logic [15:0] pick();
    logic [15:0] v;
    case ($urandom_range(0, 5))
      0: v = 16'h0000; 1: v = 16'h3C00; 2: v = 16'h3E00;
      3: v = 16'h3F00; 4: v = 16'h4000; default: v = 16'h4100;
    endcase
    if (v != 16'h0000 && $urandom_range(0, 1) == 1) v[15] = 1'b1;
    return v;
  endfunction

  // Behavioural MAC datapath: product reg, then accumulator reg with sync clear.
  always @(posedge clk or posedge rst)
    if (rst) begin
      prod_q <= 16'h0; acc_q <= 16'h0;
    end else begin
      prod_q <= dp_mul(mac_a, mac_b);
      acc_q  <= mac_clr ? 16'h0 : dp_add(acc_q, prod_q);
    end

  // Expected operand register: accepted pair, otherwise a zero bubble.
  always @(posedge clk or posedge rst)
    if (rst) begin
      exp_a <= 16'h0; exp_b <= 16'h0;
    end else begin
      exp_a <= (in_valid && in_ready) ? in_a : 16'h0;
      exp_b <= (in_valid && in_ready) ? in_b : 16'h0;
    end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    ncmp++; nerr++;
    $display("FAIL %s: bound expired at %0t", nm, $time);
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every byte handshake; checks done and operands.
  initial begin
    bit pend;
    exp_t e;
    pend = 0;
    forever begin
      @(negedge clk); #3;
      if (rst) begin pend = 0; continue; end
      chk("done", 16'(done), 16'(pend));
      chk("mac_a", mac_a, exp_a);
      chk("mac_b", mac_b, exp_b);
      pend = 0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) fail("unexpected_byte");
        else begin
          e = sb.pop_front();
          chk("out_byte", 16'(out_byte), 16'(e.b));
          chk("out_last", 16'(out_last), 16'(e.last));
          pend = e.last;
        end
      end
    end
  end

  task automatic chk_reset_outs();
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h0);
    chk("rst_mac_clr", 16'(mac_clr), 16'h0);
    chk("rst_out_valid", 16'(out_valid), 16'h0);
    chk("rst_out_last", 16'(out_last), 16'h0);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_mac_a", mac_a, 16'h0);
    chk("rst_mac_b", mac_b, 16'h0);
    chk("rst_out_byte", 16'(out_byte), 16'h0);
  endtask

  // One dot-product run. gap<0 means random gaps; abort_at>=0 resets mid-LOAD.
  task automatic run(input int n, input int gap, input int slo, input int shi,
                     input bit inj, input int abort_at);
    real sum; bit inf; logic [15:0] r; int t, g;
    sum = 0.0; inf = 0;
    for (int i = 0; i < n; i++)
      if (va[i] == 16'hFFFF || vb[i] == 16'hFFFF) inf = 1;
      else sum = sum + dec(va[i]) * dec(vb[i]);
    r = inf ? 16'hFFFF : enc(sum);
    t = 0;
    while (busy && t < 300) begin tick(); t++; end
    if (busy) fail("idle_wait");
    start = 1; len = LEN_W'(n); #1;
    chk("mac_clr_pulse", 16'(mac_clr), 16'h1);
    if (abort_at < 0) begin
      sb.push_back('{r[7:0], 1'b0});
      sb.push_back('{r[15:8], 1'b1});
    end
    tick();
    start = 0; len = LEN_W'($urandom);
    chk("mac_clr_single", 16'(mac_clr), 16'h0);
    chk("busy_run", 16'(busy), 16'h1);
    for (int i = 0; i < n; i++) begin
      if (i == abort_at) begin
        #1 rst = 1;
        #1 chk_reset_outs();
        sb.delete();
        in_valid = 0;
        tick(); tick();
        rst = 0;
        return;
      end
      g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
      for (int k = 0; k < g; k++) begin
        in_valid = 0; in_a = 16'($urandom); in_b = 16'($urandom);
        if (inj && i == 0 && k == 0) begin
          start = 1; len = 7; #1;
          chk("start_ignored_clr", 16'(mac_clr), 16'h0);
        end
        tick();
        start = 0;
      end
      in_valid = 1; in_a = va[i]; in_b = vb[i];
      t = 0;
      while (!in_ready && t < 50) begin tick(); t++; end
      if (!in_ready) fail("in_ready_wait");
      tick();
    end
    in_valid = 0;
    t = 0;
    while (!out_valid && t < 20) begin
      if (n == 0) chk("len0_in_ready", 16'(in_ready), 16'h0);
      tick(); t++;
    end
    chk("capture_latency", 16'(t), 16'(PD));
    for (int k = 0; k < slo; k++) begin
      chk("lo_stall_byte", 16'(out_byte), 16'(r[7:0]));
      chk("lo_stall_valid", 16'(out_valid), 16'h1);
      tick();
    end
    out_ready = 1; tick();
    out_ready = 0;
    for (int k = 0; k < shi; k++) begin
      chk("hi_stall_byte", 16'(out_byte), 16'(r[15:8]));
      chk("hi_stall_last", 16'(out_last), 16'h1);
      tick();
    end
    out_ready = 1; tick();
    out_ready = 0;
    chk("idle_after", 16'(busy), 16'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1;
    #20 chk_reset_outs();
    @(negedge clk); rst = 0; #1;

    // Basic 2-pair run, then with bubbles.
    va[0] = 16'h3E00; vb[0] = 16'h4000; va[1] = 16'h3F00; vb[1] = 16'h4000;
    run(2, 0, 0, 0, 0, -1);
    run(2, 1, 0, 0, 0, -1);
    run(2, 4, 0, 0, 0, -1);
    // Zero length.
    run(0, 0, 0, 0, 0, -1);
    // Output stalls.
    run(2, 0, 5, 3, 0, -1);
    // start during LOAD is ignored.
    run(2, 2, 0, 0, 1, -1);
    // Special codes pass through untouched.
    va[0] = 16'hFFFF; vb[0] = 16'h3E00; va[1] = 16'h7DFE; vb[1] = 16'hFDFE;
    run(2, 0, 1, 0, 0, -1);
    // Randomized runs.
    for (int j = 0; j < 20; j++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin va[i] = pick(); vb[i] = pick(); end
      run(n, -1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, -1);
    end
    // Reset mid-LOAD, then a fresh run.
    va[0] = 16'h4000; vb[0] = 16'h4000; va[1] = 16'h4000; vb[1] = 16'h4000;
    va[2] = 16'h4000; vb[2] = 16'h4000;
    run(3, 0, 0, 0, 0, 1);
    va[0] = 16'h3E00; vb[0] = 16'h3E00;
    run(1, 0, 0, 0, 0, -1);

    repeat (4) tick();
    if (sb.size() != 0) fail("scoreboard_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
